// File: rtl/video_out_pkg.sv
// Shared defaults and helpers for the N-channel bilinear video output blender.
// Optional rounding is selected with VIDEO_OUT_BILINEAR_ROUND_EN (see lane).
package video_out_pkg;

    localparam int CH_DEF      = 3;
    localparam int TAP_W_DEF   = 6;
    localparam int COEFF_W_DEF = 6;
    localparam int OUT_W_DEF   = 8;

    // Half an output LSB for a given right shift; zero when nothing is shifted out.
    function automatic int unsigned round_const(input int shift);
        return (shift > 0) ? (32'd1 << (shift - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/video_out_bilinear_lane.sv
// One colour channel of the blender: S2 products and S3 sum/round/shift.
// VIDEO_OUT_BILINEAR_ROUND_EN selects round-half-up instead of truncation.
module video_out_bilinear_lane
    import video_out_pkg::*;
#(
    parameter int TAP_W   = TAP_W_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               adv_i,
    input  logic               load_i,
    input  logic [TAP_W-1:0]   tap0_i,
    input  logic [TAP_W-1:0]   tap1_i,
    input  logic [COEFF_W:0]   w0_i,
    input  logic [COEFF_W-1:0] w1_i,
    output logic [OUT_W-1:0]   pix_o
);

    localparam int SHIFT = TAP_W + COEFF_W - OUT_W;
    localparam int SUM_W = TAP_W + COEFF_W + 1;

`ifdef VIDEO_OUT_BILINEAR_ROUND_EN
    localparam logic [SUM_W-1:0] RND = SUM_W'(round_const(SHIFT));
`else
    localparam logic [SUM_W-1:0] RND = '0;
`endif

    logic [SUM_W-1:0] prod0_q, prod1_q, prod0_d, prod1_d, sum_d;
    logic [OUT_W-1:0] pix_q, pix_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        prod0_d = SUM_W'(tap0_i) * SUM_W'(w0_i);
        prod1_d = SUM_W'(tap1_i) * SUM_W'(w1_i);
        sum_d   = prod0_q + prod1_q + RND;
        pix_d   = OUT_W'(sum_d >> SHIFT);
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod0_q <= '0;
            prod1_q <= '0;
            pix_q   <= '0;
        end else begin
            if (adv_i) begin
                prod0_q <= prod0_d;
                prod1_q <= prod1_d;
            end
            if (load_i) begin
                pix_q <= pix_d;
            end
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/video_out_bilinear_nch.sv
// Three-stage N-channel bilinear blender: S1 input/weight regs and valid chain here,
// per-channel S2/S3 datapath in lanes. VIDEO_OUT_BILINEAR_ROUND_EN enables rounding.
module video_out_bilinear_nch
    import video_out_pkg::*;
#(
    parameter int CH      = CH_DEF,
    parameter int TAP_W   = TAP_W_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [COEFF_W-1:0]    coeff,
    input  logic [CH*TAP_W-1:0]   tap0,
    input  logic [CH*TAP_W-1:0]   tap1,
    output logic                  out_valid,
    output logic [CH*OUT_W-1:0]   pixel_out
);

    localparam logic [COEFF_W:0] FULL_W = {1'b1, {COEFF_W{1'b0}}};

    logic [CH*TAP_W-1:0] tap0_q, tap1_q;
    logic [COEFF_W:0]    w0_q, w0_d;
    logic [COEFF_W-1:0]  w1_q;
    logic [2:0]          vld_q;
    logic                adv;
    logic                load_out;

    // Flush freezes the data path for the cycle so only the valid bits change.
    assign adv      = ce & ~flush;
    assign load_out = adv & vld_q[1];
    assign w0_d     = FULL_W - {1'b0, coeff};

    // NOTE: data registers are reset too, since pixel_out must read 0 straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap0_q <= '0;
            tap1_q <= '0;
            w0_q   <= '0;
            w1_q   <= '0;
            vld_q  <= '0;
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (ce) begin
                vld_q <= {vld_q[1:0], in_valid};
            end
            if (adv) begin
                tap0_q <= tap0;
                tap1_q <= tap1;
                w0_q   <= w0_d;
                w1_q   <= coeff;
            end
        end
    end

    assign out_valid = vld_q[2];

    for (genvar k = 0; k < CH; k++) begin : g_lane
        video_out_bilinear_lane #(
            .TAP_W   (TAP_W),
            .COEFF_W (COEFF_W),
            .OUT_W   (OUT_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .adv_i   (adv),
            .load_i  (load_out),
            .tap0_i  (tap0_q[k*TAP_W +: TAP_W]),
            .tap1_i  (tap1_q[k*TAP_W +: TAP_W]),
            .w0_i    (w0_q),
            .w1_i    (w1_q),
            .pix_o   (pixel_out[k*OUT_W +: OUT_W])
        );
    end

endmodule
